// File: rtl/imem_loader.sv
// Boot loader: frames a little-endian byte stream (word count, then words) into
// two-cycle instruction-memory writes. Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter logic [13:0] BASE_ADDR = 14'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic [13:0] imem_addr,
   output logic [31:0] imem_data,
   output logic        imem_wr_en,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [14:0] words_written
);

   // state     | meaning
   // S_HDR     | collecting the 4-byte word count
   // S_DATA    | collecting a 4-byte instruction word
   // S_WR_SETUP| addr/data presented, write enable low
   // S_WR_COMMIT| addr/data held, write enable high for one cycle
   // S_CSUM    | collecting the 4-byte checksum trailer
   // S_DONE    | load complete, core released
   // S_ERR     | framing or checksum failure, core held
   typedef enum logic [2:0] {
      S_HDR, S_DATA, S_WR_SETUP, S_WR_COMMIT, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state, next_state;
   logic [1:0]  byte_cnt;
   logic [31:0] count;
   logic [31:0] word;
   logic        take;
   logic        last_byte;
   logic [31:0] hdr_full;
   logic [31:0] word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum;
`endif

   always_comb begin
      next_state = state;
      take       = in_valid && in_ready;
      last_byte  = take && (byte_cnt == 2'd3);
      hdr_full   = {in_data, count[23:0]};
      word_full  = {in_data, word[23:0]};
      case (state)
         S_HDR: begin
            if (last_byte) begin
               if (hdr_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  next_state = S_CSUM;
`else
                  next_state = S_DONE;
`endif
               end else if (hdr_full > 32'd16384) begin
                  next_state = S_ERR;
               end else begin
                  next_state = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (last_byte) next_state = S_WR_SETUP;
         end
         S_WR_SETUP: next_state = S_WR_COMMIT;
         S_WR_COMMIT: begin
            if ({17'd0, words_written + 15'd1} == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               next_state = S_CSUM;
`else
               next_state = S_DONE;
`endif
            end else begin
               next_state = S_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (last_byte) next_state = (word_full == sum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE:  next_state = S_DONE;
         S_ERR:   next_state = S_ERR;
         default: next_state = S_ERR;
      endcase
   end

   // Outputs are registered from next_state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_HDR;
         byte_cnt      <= 2'd0;
         count         <= 32'd0;
         word          <= 32'd0;
         in_ready      <= 1'b0;
         imem_addr     <= 14'd0;
         imem_data     <= 32'd0;
         imem_wr_en    <= 1'b0;
         cpu_hold      <= 1'b1;
         done          <= 1'b0;
         error         <= 1'b0;
         words_written <= 15'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum           <= 32'd0;
`endif
      end else begin
         state      <= next_state;
         in_ready   <= (next_state == S_HDR) || (next_state == S_DATA) ||
                       (next_state == S_CSUM);
         imem_wr_en <= (next_state == S_WR_COMMIT);
         cpu_hold   <= (next_state != S_DONE);
         done       <= (next_state == S_DONE);
         error      <= (next_state == S_ERR);

         if (next_state != state) byte_cnt <= 2'd0;
         else if (take)           byte_cnt <= byte_cnt + 2'd1;

         if (take && state == S_HDR) count[{byte_cnt, 3'b000} +: 8] <= in_data;
         if (take && (state == S_DATA || state == S_CSUM))
            word[{byte_cnt, 3'b000} +: 8] <= in_data;

         if (state == S_DATA && next_state == S_WR_SETUP) begin
            imem_addr <= BASE_ADDR + words_written[13:0];
            imem_data <= word_full;
         end

         if (state == S_WR_COMMIT) begin
            words_written <= words_written + 15'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= sum + imem_data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 16383) share one stream;
// a queue-based reference predicts every write and the final status.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        rdy0, wr0, hold0, done0, err0;
   logic [13:0] addr0;
   logic [31:0] data0;
   logic [14:0] ww0;
   logic        rdy1, wr1, hold1, done1, err1;
   logic [13:0] addr1;
   logic [31:0] data1;
   logic [14:0] ww1;

   int n_pass = 0;
   int n_total = 0;

   logic [13:0] qa0[$], qa1[$];
   logic [31:0] qd0[$], qd1[$];
   logic        pwr0 = 1'b0, pwr1 = 1'b0;
   logic [13:0] pa0 = '0, pa1 = '0;
   logic [31:0] pd0 = '0, pd1 = '0;

   imem_loader #(.BASE_ADDR(14'd0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .imem_addr(addr0), .imem_data(data0), .imem_wr_en(wr0),
      .cpu_hold(hold0), .done(done0), .error(err0), .words_written(ww0));

   imem_loader #(.BASE_ADDR(14'd16383)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .imem_addr(addr1), .imem_data(data1), .imem_wr_en(wr1),
      .cpu_hold(hold1), .done(done1), .error(err1), .words_written(ww1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Write-port monitor: one-cycle pulses, addr/data stable in the cycle before.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr0) begin
            check("wr0_pulse_isolated", {31'd0, pwr0}, 32'd0);
            check("wr0_addr_stable", {18'd0, addr0}, {18'd0, pa0});
            check("wr0_data_stable", data0, pd0);
            qa0.push_back(addr0);
            qd0.push_back(data0);
         end
         if (wr1) begin
            check("wr1_pulse_isolated", {31'd0, pwr1}, 32'd0);
            check("wr1_addr_stable", {18'd0, addr1}, {18'd0, pa1});
            check("wr1_data_stable", data1, pd1);
            qa1.push_back(addr1);
            qd1.push_back(data1);
         end
      end
      pwr0 = wr0; pa0 = addr0; pd0 = data0;
      pwr1 = wr1; pa1 = addr1; pd1 = data1;
   end

   task automatic clear_queues();
      qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_queues();
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int n;
      in_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      @(negedge clk);
      while (!rdy0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", {31'd0, rdy0}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], max_gap);
   endtask

   task automatic run_case(input string tag, input logic [31:0] hdr, input logic [31:0] words[$],
                           input bit bad_trailer, input int max_gap, input bit skip_reset);
      logic [31:0] sum;
      bit          exp_err;
      int          n_exp;
      int          cyc;
      sum = 32'd0;
      if (!skip_reset) do_reset();
      send_word(hdr, max_gap);
      if (hdr <= 32'd16384) begin
         foreach (words[i]) begin
            send_word(words[i], max_gap);
            sum = sum + words[i];
         end
         if (CSUM) send_word(bad_trailer ? sum + 32'd1 : sum, max_gap);
      end
      cyc = 0;
      while (!(done0 || err0) && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 100) check({tag, "_finish_timeout"}, 32'd0, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      exp_err = (hdr > 32'd16384) || (CSUM && bad_trailer);
      n_exp   = (hdr > 32'd16384) ? 0 : words.size();
      check({tag, "_done"},     {31'd0, done0},  {31'd0, !exp_err});
      check({tag, "_error"},    {31'd0, err0},   {31'd0, exp_err});
      check({tag, "_cpu_hold"}, {31'd0, hold0},  {31'd0, exp_err});
      check({tag, "_in_ready"}, {31'd0, rdy0},   32'd0);
      check({tag, "_words"},    {17'd0, ww0},    n_exp);
      check({tag, "_done_b1"},  {31'd0, done1},  {31'd0, !exp_err});
      check({tag, "_words_b1"}, {17'd0, ww1},    n_exp);
      check({tag, "_nwr0"}, qa0.size(), n_exp);
      check({tag, "_nwr1"}, qa1.size(), n_exp);
      for (int i = 0; i < n_exp && i < qa0.size() && i < qa1.size(); i++) begin
         check({tag, "_addr0"}, {18'd0, qa0[i]}, i % 16384);
         check({tag, "_data0"}, qd0[i], words[i]);
         check({tag, "_addr1"}, {18'd0, qa1[i]}, (16383 + i) % 16384);
         check({tag, "_data1"}, qd1[i], words[i]);
      end
   endtask

   initial begin
      logic [31:0] wq[$];
      logic [31:0] none[$];
      int          n;

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, rdy0}, 32'd0);
      check("rst_addr",     {18'd0, addr0}, 32'd0);
      check("rst_data",     data0, 32'd0);
      check("rst_wr_en",    {31'd0, wr0}, 32'd0);
      check("rst_cpu_hold", {31'd0, hold0}, 32'd1);
      check("rst_done",     {31'd0, done0}, 32'd0);
      check("rst_error",    {31'd0, err0}, 32'd0);
      check("rst_words",    {17'd0, ww0}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready_after", {31'd0, rdy0}, 32'd1);

      wq = {32'h00100513, 32'h0000006F};
      run_case("two_words", 32'd2, wq, 1'b0, 0, 1'b0);
      run_case("zero_count", 32'd0, none, 1'b0, 2, 1'b0);
      run_case("over_count", 32'd16385, none, 1'b0, 1, 1'b0);

      // Mid-load reset after 6 bytes of a 3-word load
      do_reset();
      send_word(32'd3, 3);
      send_byte(8'hA5, 3);
      send_byte(8'h5A, 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_queues();
      check("mid_rst_in_ready", {31'd0, rdy0}, 32'd0);
      check("mid_rst_addr",     {18'd0, addr0}, 32'd0);
      check("mid_rst_data",     data0, 32'd0);
      check("mid_rst_cpu_hold", {31'd0, hold0}, 32'd1);
      check("mid_rst_done",     {31'd0, done0}, 32'd0);
      check("mid_rst_words",    {17'd0, ww0}, 32'd0);
      @(posedge clk);
      #1;
      check("mid_rst_ready_next", {31'd0, rdy0}, 32'd1);
      wq = {32'hDEADBEEF};
      run_case("after_reset", 32'd1, wq, 1'b0, 2, 1'b1);

      wq = {32'h00000001, 32'hFFFFFFFF};
      run_case("csum_good", 32'd2, wq, 1'b0, 1, 1'b0);
      run_case("csum_bad", 32'd2, wq, 1'b1, 1, 1'b0);

      for (int r = 0; r < 4; r++) begin
         wq.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         run_case($sformatf("rand%0d", r), n, wq, r[0], 3, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
